cpu_wb_ext: RTL

//  Registered writeback stage for the PLP core; successor to the combinational writeback mux.

---
 rtl/cpu_wb_ext.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/cpu_wb_ext.sv
// Registered writeback stage: selects the writeback source, extracts big-endian
// sub-word loads and waits (with timeout) on a multi-cycle data-memory acknowledge.
module cpu_wb_ext #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int TIMEOUT = 15,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          mem_c_rfw,
  input  logic [1:0]    mem_c_wbsource,
  input  logic [1:0]    mem_c_lsize,
  input  logic          mem_c_lsign,
  input  logic [DW-1:0] mem_alu_r,
  input  logic [DW-1:0] mem_dmem_in,
  input  logic          mem_dmem_ack,
  input  logic [AW-1:0] mem_rf_waddr,
  input  logic [DW-1:0] mem_jalra,
  output logic          stall,
  output logic          rfw,
  output logic [DW-1:0] wdata,
  output logic [AW-1:0] rf_waddr,
  output logic          ld_timeout,
  output logic [CW-1:0] stall_cnt
);
  localparam int LW = $clog2(DW / 8);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state_q, state_d;
  logic          rfw_q, rfw_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [AW-1:0] rf_waddr_q, rf_waddr_d;
  logic          ld_timeout_q, ld_timeout_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic          cap_rfw_q, cap_rfw_d;
  logic [AW-1:0] cap_waddr_q, cap_waddr_d;
  logic [1:0]    cap_lsize_q, cap_lsize_d;
  logic          cap_lsign_q, cap_lsign_d;
  logic [LW-1:0] cap_off_q, cap_off_d;
  logic          stall_c;
  logic          load;
  logic [DW-1:0] sel_data;

  // Big-endian lanes: offset 0 is the most-significant byte, so the right
  // shift amount is the bit-inverted lane index scaled to bits.
  function automatic logic [DW-1:0] extract(input logic [DW-1:0] d, input logic [1:0] sz,
                                            input logic sgn, input logic [LW-1:0] off);
    logic [LW+2:0] byte_sh;
    logic [LW+2:0] half_sh;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    byte_sh = {~off, 3'b000};
    half_sh = {~off[LW-1:1], 4'b0000};
    byte_v  = 8'(d >> byte_sh);
    half_v  = 16'(d >> half_sh);
    case (sz)
      2'b10:   extract = {{(DW-8){sgn & byte_v[7]}}, byte_v};
      2'b01:   extract = {{(DW-16){sgn & half_v[15]}}, half_v};
      default: extract = d;
    endcase
  endfunction

  assign load = in_valid && (mem_c_wbsource == 2'b01);

  always_comb begin
    case (mem_c_wbsource)
      2'b00:   sel_data = mem_alu_r;
      2'b01:   sel_data = extract(mem_dmem_in, mem_c_lsize, mem_c_lsign, mem_alu_r[LW-1:0]);
      2'b10:   sel_data = mem_jalra;
      default: sel_data = '0;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d      = state_q;
    rfw_d        = 1'b0;
    wdata_d      = wdata_q;
    rf_waddr_d   = rf_waddr_q;
    ld_timeout_d = 1'b0;
    wait_cnt_d   = wait_cnt_q;
    cap_rfw_d    = cap_rfw_q;
    cap_waddr_d  = cap_waddr_q;
    cap_lsize_d  = cap_lsize_q;
    cap_lsign_d  = cap_lsign_q;
    cap_off_d    = cap_off_q;
    stall_c      = 1'b0;

    case (state_q)
      IDLE: begin
        if (load && !mem_dmem_ack) begin
          stall_c     = 1'b1;
          state_d     = WAIT;
          wait_cnt_d  = TW'(1);
          cap_rfw_d   = mem_c_rfw && (mem_rf_waddr != '0);
          cap_waddr_d = mem_rf_waddr;
          cap_lsize_d = mem_c_lsize;
          cap_lsign_d = mem_c_lsign;
          cap_off_d   = mem_alu_r[LW-1:0];
        end else if (in_valid) begin
          rfw_d      = mem_c_rfw && (mem_rf_waddr != '0);
          rf_waddr_d = mem_rf_waddr;
          wdata_d    = sel_data;
        end
      end
      WAIT: begin
        if (mem_dmem_ack) begin
          rfw_d      = cap_rfw_q;
          rf_waddr_d = cap_waddr_q;
          wdata_d    = extract(mem_dmem_in, cap_lsize_q, cap_lsign_q, cap_off_q);
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == TW'(TIMEOUT)) begin
          ld_timeout_d = 1'b1;
          state_d      = IDLE;
          wait_cnt_d   = '0;
        end else begin
          stall_c    = 1'b1;
          wait_cnt_d = wait_cnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst) stall_c = 1'b0;

    stall_cnt_d = stall_cnt_q;
    if (stall_c && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q      <= IDLE;
      rfw_q        <= 1'b0;
      wdata_q      <= '0;
      rf_waddr_q   <= '0;
      ld_timeout_q <= 1'b0;
      stall_cnt_q  <= '0;
      wait_cnt_q   <= '0;
      cap_rfw_q    <= 1'b0;
      cap_waddr_q  <= '0;
      cap_lsize_q  <= '0;
      cap_lsign_q  <= 1'b0;
      cap_off_q    <= '0;
    end else begin
      state_q      <= state_d;
      rfw_q        <= rfw_d;
      wdata_q      <= wdata_d;
      rf_waddr_q   <= rf_waddr_d;
      ld_timeout_q <= ld_timeout_d;
      stall_cnt_q  <= stall_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      cap_rfw_q    <= cap_rfw_d;
      cap_waddr_q  <= cap_waddr_d;
      cap_lsize_q  <= cap_lsize_d;
      cap_lsign_q  <= cap_lsign_d;
      cap_off_q    <= cap_off_d;
    end
  end

  assign stall      = stall_c;
  assign rfw        = rfw_q;
  assign wdata      = wdata_q;
  assign rf_waddr   = rf_waddr_q;
  assign ld_timeout = ld_timeout_q;
  assign stall_cnt  = stall_cnt_q;
endmodule
